// File: rtl/wordle_guess_ctrl.sv
// Wordle guess controller: button-driven 5-letter guess entry, sequential
// green/yellow/gray scoring against a target word, guess counting and win/lose lock.
module wordle_guess_ctrl #(
  parameter int          MAX_GUESSES  = 6,
  parameter logic [7:0]  LETTER_RESET = 8'h41
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        new_game,
  input  logic [39:0] target_word,
  input  logic        BtnU,
  input  logic        BtnD,
  input  logic        BtnR,
  input  logic        BtnL,
  input  logic        BtnC,
  output logic [7:0]  sel_letter,
  output logic [2:0]  cursor,
  output logic [39:0] guess_buf,
  output logic        busy,
  output logic [9:0]  feedback,
  output logic        feedback_valid,
  output logic [2:0]  guess_count,
  output logic        win,
  output logic        lose
);

  typedef enum logic [2:0] {
    S_IDLE, S_EDIT, S_SCORE_G, S_SCORE_Y, S_REPORT, S_LOCKED
  } state_t;

  localparam logic [1:0] FB_GRAY   = 2'b01;
  localparam logic [1:0] FB_YELLOW = 2'b10;
  localparam logic [1:0] FB_GREEN  = 2'b11;
  localparam logic [7:0] LETTER_A  = 8'h41;
  localparam logic [7:0] LETTER_Z  = 8'h5A;

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_sel;
  logic [2:0]        r_cursor;
  logic [0:4][7:0]   r_buf;      // element 0 lands at [39:32]
  logic [0:4][1:0]   r_fb;       // working feedback, element 0 at [9:8]
  logic [4:0]        r_used;     // target letters already claimed
  logic [2:0]        r_i;
  logic [2:0]        r_j;
  logic [9:0]        r_feedback;
  logic [2:0]        r_count;
  logic              r_win;
  logic              r_lose;

  logic              w_clear_game;
  logic              w_all_green;
  logic              w_last_guess;
  logic [7:0]        w_target_i;
  logic [7:0]        w_target_j;

  function automatic logic [7:0] target_letter(input logic [39:0] word, input logic [2:0] k);
    case (k)
      3'd0:    return word[39:32];
      3'd1:    return word[31:24];
      3'd2:    return word[23:16];
      3'd3:    return word[15:8];
      3'd4:    return word[7:0];
      default: return 8'h00;
    endcase
  endfunction

  assign w_clear_game = new_game &&
                        (r_state == S_IDLE || r_state == S_EDIT || r_state == S_LOCKED);
  assign w_all_green  = (r_fb == {5{FB_GREEN}});
  assign w_last_guess = ((r_count + 3'd1) == 3'(MAX_GUESSES));
  assign w_target_i   = target_letter(target_word, r_i);
  assign w_target_j   = target_letter(target_word, r_j);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge Clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: the default assignment up front keeps this block purely
  // combinational; a path that skipped it would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_LOCKED: if (new_game) w_next_state = S_EDIT;
      S_EDIT:           if (!new_game && BtnC && r_cursor == 3'd5) w_next_state = S_SCORE_G;
      S_SCORE_G:        if (r_i == 3'd4) w_next_state = S_SCORE_Y;
      S_SCORE_Y:        if (r_i == 3'd4 && r_j == 3'd4) w_next_state = S_REPORT;
      S_REPORT:         w_next_state = (w_all_green || w_last_guess) ? S_LOCKED : S_EDIT;
      default:          w_next_state = S_IDLE;
    endcase
  end

  // NOTE: the letter buffer is a plain register bank (not RAM) because every
  // slot is visible on guess_buf, so it is reset together with the rest.
  always_ff @(posedge Clk) begin
    if (!reset_n || w_clear_game) begin
      r_sel      <= LETTER_RESET;
      r_cursor   <= '0;
      r_buf      <= '0;
      r_fb       <= '0;
      r_used     <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_feedback <= '0;
      r_count    <= '0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      case (r_state)
        S_EDIT: begin
          // One button per cycle; BtnC wins arbitration even when it is refused.
          if (BtnC) begin
            if (r_cursor == 3'd5) begin
              r_used <= '0;
              r_i    <= '0;
              r_j    <= '0;
            end
          end else if (BtnL) begin
            if (r_cursor != 3'd0) begin
              r_cursor                <= r_cursor - 3'd1;
              r_buf[r_cursor - 3'd1]  <= 8'h00;
            end
          end else if (BtnR) begin
            if (r_cursor < 3'd5) begin
              r_buf[r_cursor] <= r_sel;
              r_cursor        <= r_cursor + 3'd1;
            end
          end else if (BtnU) begin
            r_sel <= (r_sel == LETTER_Z) ? LETTER_A : r_sel + 8'd1;
          end else if (BtnD) begin
            r_sel <= (r_sel == LETTER_A) ? LETTER_Z : r_sel - 8'd1;
          end
        end
        S_SCORE_G: begin
          if (r_buf[r_i] == w_target_i) begin
            r_fb[r_i]   <= FB_GREEN;
            r_used[r_i] <= 1'b1;
          end else begin
            r_fb[r_i]   <= FB_GRAY;
          end
          r_i <= (r_i == 3'd4) ? 3'd0 : r_i + 3'd1;
          r_j <= '0;
        end
        S_SCORE_Y: begin
          // A yellow hit turns fb[i] non-gray, which stops further matches for i.
          if (r_fb[r_i] == FB_GRAY && !r_used[r_j] && r_buf[r_i] == w_target_j) begin
            r_fb[r_i]   <= FB_YELLOW;
            r_used[r_j] <= 1'b1;
          end
          if (r_j == 3'd4) begin
            r_j <= '0;
            r_i <= (r_i == 3'd4) ? 3'd0 : r_i + 3'd1;
          end else begin
            r_j <= r_j + 3'd1;
          end
        end
        S_REPORT: begin
          r_feedback <= r_fb;
          r_count    <= r_count + 3'd1;
          if (w_all_green) begin
            r_win <= 1'b1;
          end else if (w_last_guess) begin
            r_lose <= 1'b1;
          end else begin
            r_buf    <= '0;
            r_cursor <= '0;
            r_sel    <= LETTER_RESET;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_letter     = r_sel;
    cursor         = r_cursor;
    guess_buf      = r_buf;
    guess_count    = r_count;
    win            = r_win;
    lose           = r_lose;
    busy           = (r_state == S_SCORE_G) || (r_state == S_SCORE_Y) || (r_state == S_REPORT);
    feedback_valid = (r_state == S_REPORT);
    // The registered copy only updates at the end of REPORT, so show the live result during it.
    feedback       = (r_state == S_REPORT) ? r_fb : r_feedback;
  end

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// Self-checking bench for wordle_guess_ctrl: directed scenarios plus randomized
// games compared against a word-level Wordle reference model.
module tb_wordle_guess_ctrl;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        new_game;
  logic [39:0] target_word;
  logic        BtnU, BtnD, BtnR, BtnL, BtnC;
  logic [7:0]  sel_letter;
  logic [2:0]  cursor;
  logic [39:0] guess_buf;
  logic        busy;
  logic [9:0]  feedback;
  logic        feedback_valid;
  logic [2:0]  guess_count;
  logic        win;
  logic        lose;

  wordle_guess_ctrl #(.MAX_GUESSES(6), .LETTER_RESET(8'h41)) dut (
    .Clk(Clk), .reset_n(reset_n), .new_game(new_game), .target_word(target_word),
    .BtnU(BtnU), .BtnD(BtnD), .BtnR(BtnR), .BtnL(BtnL), .BtnC(BtnC),
    .sel_letter(sel_letter), .cursor(cursor), .guess_buf(guess_buf), .busy(busy),
    .feedback(feedback), .feedback_valid(feedback_valid), .guess_count(guess_count),
    .win(win), .lose(lose)
  );

  always #5 Clk = ~Clk;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the player-visible state
  logic [7:0] m_sel;
  int         m_cursor;
  logic [7:0] m_buf [5];
  int         m_count;
  logic       m_win, m_lose;
  logic [9:0] m_fb;
  bit         m_editable;

  function automatic logic [7:0] letter_step(input logic [7:0] x, input int delta);
    int v;
    v = (int'(x) - 65 + delta + 26) % 26;
    return 8'(65 + v);
  endfunction

  function automatic logic [39:0] m_guess();
    logic [39:0] r;
    for (int k = 0; k < 5; k++) r[8*(4-k) +: 8] = m_buf[k];
    return r;
  endfunction

  // Standard Wordle scoring: exact matches first, then leftmost unclaimed target letter.
  function automatic logic [9:0] ref_score(input logic [39:0] tgt, input logic [39:0] gs);
    logic [7:0]  t [5];
    logic [7:0]  g [5];
    int          res [5];
    bit          used [5];
    logic [9:0]  out;
    for (int k = 0; k < 5; k++) begin
      t[k] = tgt[8*(4-k) +: 8];
      g[k] = gs[8*(4-k) +: 8];
      used[k] = (g[k] == t[k]);
      res[k]  = used[k] ? 3 : 1;
    end
    for (int i = 0; i < 5; i++) begin
      if (res[i] == 1) begin
        for (int j = 0; j < 5; j++) begin
          if (!used[j] && g[i] == t[j]) begin
            res[i]  = 2;
            used[j] = 1'b1;
            break;
          end
        end
      end
    end
    for (int k = 0; k < 5; k++) out[2*(4-k) +: 2] = 2'(res[k]);
    return out;
  endfunction

  function automatic logic [67:0] dut_vec();
    return {sel_letter, cursor, guess_buf, busy, feedback, feedback_valid, guess_count, win, lose};
  endfunction

  function automatic logic [67:0] model_vec();
    return {m_sel, 3'(m_cursor), m_guess(), 1'b0, m_fb, 1'b0, 3'(m_count), m_win, m_lose};
  endfunction

  function automatic logic [39:0] rand_word(input string alpha);
    logic [39:0] w;
    for (int k = 0; k < 5; k++) w[8*(4-k) +: 8] = alpha[$urandom_range(0, alpha.len() - 1)];
    return w;
  endfunction

  task automatic reset_model();
    m_sel = 8'h41; m_cursor = 0; m_count = 0; m_win = 1'b0; m_lose = 1'b0; m_fb = '0;
    for (int k = 0; k < 5; k++) m_buf[k] = 8'h00;
  endtask

  task automatic model_apply(input logic [4:0] b);
    if (b[4]) begin
    end else if (b[3]) begin
      if (m_cursor > 0) begin m_cursor--; m_buf[m_cursor] = 8'h00; end
    end else if (b[2]) begin
      if (m_cursor < 5) begin m_buf[m_cursor] = m_sel; m_cursor++; end
    end else if (b[1]) m_sel = letter_step(m_sel, 1);
    else if (b[0])     m_sel = letter_step(m_sel, -1);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    {BtnC, BtnL, BtnR, BtnU, BtnD} = b;
    tick();
    {BtnC, BtnL, BtnR, BtnU, BtnD} = '0;
    if (m_editable) model_apply(b);
  endtask

  task automatic start_game(input logic [39:0] tgt);
    target_word = tgt;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    reset_model();
    m_editable = 1'b1;
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL new_game_clear: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic type_word(input logic [39:0] w);
    logic [7:0] c;
    int         steps;
    for (int k = 0; k < 5; k++) begin
      c = w[8*(4-k) +: 8];
      if ($urandom_range(0, 1) == 1) begin
        steps = (int'(m_sel) - int'(c) + 26) % 26;
        repeat (steps) press(B_D);
      end else begin
        steps = (int'(c) - int'(m_sel) + 26) % 26;
        repeat (steps) press(B_U);
      end
      n_checks++;
      if (sel_letter !== c) begin
        n_fail++; $display("FAIL sel_reach: got %h expected %h", sel_letter, c);
      end
      press(B_R);
    end
    n_checks++;
    if (guess_buf !== w || cursor !== 3'd5) begin
      n_fail++; $display("FAIL typed_word: got %h/%0d expected %h/5", guess_buf, cursor, w);
    end
  endtask

  task automatic submit(input logic [39:0] tgt, input bit noise);
    logic [9:0]  exp_fb;
    logic [39:0] exp_guess;
    int          k;
    bit          busy_ok;
    exp_guess = m_guess();
    exp_fb    = ref_score(tgt, exp_guess);
    press(B_C);
    m_editable = 1'b0;
    n_checks++;
    if (feedback !== m_fb) begin
      n_fail++; $display("FAIL fb_hold_busy: got %b expected %b", feedback, m_fb);
    end
    k = 1;
    busy_ok = 1'b1;
    while (!feedback_valid && k < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (noise) begin
        {BtnC, BtnL, BtnR, BtnU, BtnD} = 5'($urandom);
        new_game = ($urandom_range(0, 3) == 0);
      end
      tick();
      k++;
    end
    {BtnC, BtnL, BtnR, BtnU, BtnD} = '0;
    new_game = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    n_checks++;
    if (k != 31) begin
      n_fail++; $display("FAIL latency: got %0d cycles expected 31", k);
    end
    n_checks++;
    if (!busy_ok) begin
      n_fail++; $display("FAIL busy_window: got a low busy cycle expected busy high t+1..t+31");
    end
    n_checks++;
    if (feedback !== exp_fb || guess_buf !== exp_guess) begin
      n_fail++; $display("FAIL report_fb: got %b/%h expected %b/%h", feedback, guess_buf, exp_fb, exp_guess);
    end
    tick();
    m_fb = exp_fb;
    m_count++;
    if (exp_fb == 10'h3FF)  m_win = 1'b1;
    else if (m_count == 6)  m_lose = 1'b1;
    else begin
      m_cursor = 0; m_sel = 8'h41;
      for (int q = 0; q < 5; q++) m_buf[q] = 8'h00;
    end
    m_editable = !(m_win || m_lose);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL post_report: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; new_game = 1'b0; target_word = '0;
    {BtnC, BtnL, BtnR, BtnU, BtnD} = '0;
    m_editable = 1'b0;
    reset_model();
    tick(); tick();
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", dut_vec(), model_vec());
    end
    reset_n = 1'b1;
    press(B_R); press(B_U); press(B_C);
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL idle_ignores: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_win();
    start_game("ROBOT");
    type_word("ROBOT");
    submit("ROBOT", 1'b0);
    n_checks++;
    if (feedback !== 10'b1111111111 || win !== 1'b1 || guess_count !== 3'd1) begin
      n_fail++; $display("FAIL robot_win: got %b/%b/%0d expected 1111111111/1/1", feedback, win, guess_count);
    end
    press(B_R); press(B_U); press(B_L);
    n_checks++;
    if (cursor !== 3'd5 || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL locked_ignores: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_duplicates();
    start_game("ABBOT");
    type_word("BANAL");
    submit("ABBOT", 1'b0);
    n_checks++;
    if (feedback !== 10'b1010010101 || win !== 1'b0 || cursor !== 3'd0) begin
      n_fail++; $display("FAIL banal_dup: got %b/%b/%0d expected 1010010101/0/0", feedback, win, cursor);
    end
  endtask

  task automatic test_selector_edit();
    press(B_D);
    n_checks++;
    if (sel_letter !== 8'h5A) begin
      n_fail++; $display("FAIL wrap_down: got %h expected 5a", sel_letter);
    end
    press(B_U);
    n_checks++;
    if (sel_letter !== 8'h41) begin
      n_fail++; $display("FAIL wrap_up: got %h expected 41", sel_letter);
    end
    press(B_R | B_U);
    n_checks++;
    if (guess_buf[39:32] !== 8'h41 || cursor !== 3'd1 || sel_letter !== 8'h41) begin
      n_fail++; $display("FAIL r_beats_u: got %h/%0d/%h expected 41/1/41", guess_buf[39:32], cursor, sel_letter);
    end
    press(B_U); press(B_R); press(B_U); press(B_R);
    press(B_C);
    n_checks++;
    if (busy !== 1'b0 || cursor !== 3'd3 || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL short_submit: got %h expected %h", dut_vec(), model_vec());
    end
    press(B_L);
    n_checks++;
    if (cursor !== 3'd2 || guess_buf[23:16] !== 8'h00 || guess_buf[31:24] !== 8'h42) begin
      n_fail++; $display("FAIL delete: got %0d/%h expected 2/4142000000", cursor, guess_buf);
    end
    press(B_L); press(B_L); press(B_L);
    n_checks++;
    if (cursor !== 3'd0 || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL del_at_zero: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_lose();
    logic [39:0] g;
    start_game("MINUS");
    for (int n = 0; n < 6; n++) begin
      do g = rand_word("MINUSAE"); while (g == "MINUS");
      type_word(g);
      submit("MINUS", 1'b0);
    end
    n_checks++;
    if (lose !== 1'b1 || win !== 1'b0 || guess_count !== 3'd6) begin
      n_fail++; $display("FAIL lose_at_six: got %b/%b/%0d expected 1/0/6", lose, win, guess_count);
    end
    press(B_R);
    start_game("MINUS");
    n_checks++;
    if (guess_count !== 3'd0 || lose !== 1'b0 || feedback !== 10'd0) begin
      n_fail++; $display("FAIL restart: got %0d/%b/%b expected 0/0/0", guess_count, lose, feedback);
    end
  endtask

  task automatic test_random_games();
    logic [39:0] tgt, g;
    for (int game = 0; game < 4; game++) begin
      tgt = rand_word("ABCDE");
      start_game(tgt);
      for (int n = 0; n < 6 && m_editable; n++) begin
        g = ($urandom_range(0, 3) == 0) ? tgt : rand_word("ABCDE");
        type_word(g);
        submit(tgt, 1'b1);
      end
    end
  endtask

  task automatic test_reset_mid_score();
    bit saw_fv;
    start_game("CRANE");
    type_word("CRATE");
    press(B_C);
    m_editable = 1'b0;
    repeat (9) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_before_abort: got %b expected 1", busy);
    end
    reset_n = 1'b0;
    tick();
    reset_model();
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL reset_abort: got %h expected %h", dut_vec(), model_vec());
    end
    reset_n = 1'b1;
    saw_fv = 1'b0;
    repeat (40) begin
      tick();
      if (feedback_valid === 1'b1) saw_fv = 1'b1;
    end
    n_checks++;
    if (saw_fv || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL no_pulse_after_abort: got fv=%b %h expected fv=0 %h", saw_fv, dut_vec(), model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_duplicates();
    test_selector_edit();
    test_lose();
    test_random_games();
    test_reset_mid_score();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
